sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO, successor to the basic synchronous FIFO. Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a selectable read mode: first-word-fall-through or registered read. Used as the generic buffer between pipeline stages and peripherals (UART/SPI RX/TX queues, bus bridges).

Parameters:
WIDTH, 32, data word width in bits (>=1).
DEPTH, 128, number of entries; power of two, >=2. ADDR_BITS = $clog2(DEPTH).
AF_THRESH, DEPTH-4, almost_full_o asserts when count >= AF_THRESH (1..DEPTH).
AE_THRESH, 4, almost_empty_o asserts when count <= AE_THRESH (0..DEPTH-1).
FWFT, 1, 1 = first-word-fall-through read; 0 = registered read, 1-cycle latency.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_ni  in  1  asynchronous active-low reset.
flush_i  in  1  synchronous clear of contents and pointers.
err_clr_i  in  1  clears the sticky overflow_o and underflow_o flags.
wdata_i  in  WIDTH  write data.
we_i  in  1  write request.
re_i  in  1  read (pop) request.
rdata_o  out  WIDTH  read data.
rvalid_o  out  1  rdata_o holds valid data (meaning depends on FWFT).
full_o  out  1  count == DEPTH.
empty_o  out  1  count == 0.
almost_full_o  out  1  count >= AF_THRESH.
almost_empty_o  out  1  count <= AE_THRESH.
count_o  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
overflow_o  out  1  sticky: a write was rejected.
underflow_o  out  1  sticky: a read was rejected.

Behaviour:
- Pointers w_ptr and r_ptr are ADDR_BITS+1 bits wide; the MSB is the wrap bit. count_o is a separate register, kept equal to w_ptr - r_ptr.
- Reset (asynchronous) sets pointers, count, overflow_o, underflow_o and the rdata_o register (FWFT=0) to 0, and rvalid_o to 0. Resulting flags: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0. Memory is not reset.
- Write accept: wa = we_i & (~full_o | (re_i & ~empty_o)). A write while full is accepted only when a read is accepted in the same cycle.
- Read accept: ra = re_i & ~empty_o. A read while empty is never accepted, even if a write occurs in the same cycle.
- On an accepted write, mem[w_addr] <= wdata_i and w_ptr increments. On an accepted read, r_ptr increments. Pointers wrap naturally modulo 2*DEPTH.
- count_o next value: +1 if wa & ~ra; -1 if ra & ~wa; unchanged otherwise.
- All status flags are combinational from registered count_o, so they change in the cycle after the accepted operation.
- Errors:
  - overflow_o sets when we_i=1 and wa=0.
  - underflow_o sets when re_i=1 and ra=0.
  - Both flags hold until err_clr_i. If a set and err_clr_i occur in the same cycle, the set wins.
- flush_i takes priority over we_i and re_i:
  - next cycle: pointers and count are 0, empty_o=1, rvalid_o=0.
  - No write occurs and no error is flagged in the flush cycle.
  - overflow_o and underflow_o are preserved.
- FWFT=1:
  - rdata_o = mem[r_addr] when ~empty_o, else all zeros.
  - rvalid_o = ~empty_o.
  - A write to an empty FIFO appears on rdata_o one cycle after the write edge.
- FWFT=0:
  - On ra, rdata_o <= mem[r_addr] at the same edge, and rvalid_o=1 for exactly that following cycle.
  - Otherwise rvalid_o=0 and rdata_o holds its last value.
  - Back-to-back reads give one word per cycle.
  - Flush clears rvalid_o but not rdata_o.
- Asserting reset mid-operation discards all contents; state is as at power-up in the same cycle.

Test Plan:
- Reset, FWFT=1, DEPTH=8, thresholds 6/2: write 0x11..0x18 one per cycle -> count_o 1..8, almost_empty_o drops when count=3, almost_full_o rises at count=6, full_o=1 at 8; rdata_o=0x11 from the cycle after the first write.
- Full FIFO: we_i=1 alone -> count stays 8, overflow_o=1; then we_i=re_i=1 with wdata 0x99 -> count stays 8, 0x11 popped; draining returns 0x12..0x18 then 0x99.
- Empty FIFO with re_i=we_i=1 (wdata 0xAA) -> underflow_o=1, count_o=1, rdata_o=0xAA next cycle; err_clr_i together with another empty read -> underflow_o stays 1; err_clr_i alone -> 0.
- FWFT=0: write 0x1,0x2,0x3, then read 3 consecutive cycles -> rvalid_o high 3 cycles with rdata_o 0x1,0x2,0x3, each one cycle after its re_i; rdata_o holds 0x3 afterwards with rvalid_o=0.
- Pointer wrap: DEPTH=4, 10 rounds of 3 writes then 3 reads with an incrementing pattern -> all data returned in order, empty_o=1 at the end, no error flags.
- Flush with 5 entries plus we_i=re_i=1 in the same cycle -> next cycle count_o=0, empty_o=1, no write, sticky flags unchanged; async reset while half full -> count_o=0 immediately.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// Request/status bundle between a sync_fifo_flags instance and its user.
// The user side drives the master modport; the FIFO takes the slave modport.
interface sync_fifo_flags_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             flush_i;
   logic             err_clr_i;
   logic [WIDTH-1:0] wdata_i;
   logic             we_i;
   logic             re_i;
   logic [WIDTH-1:0] rdata_o;
   logic             rvalid_o;
   logic             full_o;
   logic             empty_o;
   logic             almost_full_o;
   logic             almost_empty_o;
   logic [CW-1:0]    count_o;
   logic             overflow_o;
   logic             underflow_o;

   modport master (
      output flush_i, err_clr_i, wdata_i, we_i, re_i,
      input  rdata_o, rvalid_o, full_o, empty_o, almost_full_o,
             almost_empty_o, count_o, overflow_o, underflow_o
   );

   modport slave (
      input  flush_i, err_clr_i, wdata_i, we_i, re_i,
      output rdata_o, rvalid_o, full_o, empty_o, almost_full_o,
             almost_empty_o, count_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and FWFT/registered read.
module sync_fifo_flags #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 128,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4,
   parameter bit FWFT      = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   sync_fifo_flags_if.slave bus
);
   localparam int ADDR_BITS = $clog2(DEPTH);
   localparam int CW        = ADDR_BITS + 1;
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [WIDTH-1:0]     r_mem [DEPTH];
   logic [CW-1:0]        r_wptr;
   logic [CW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic                 r_ovf;
   logic                 r_unf;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_ra;
   logic                 w_wa;
   logic                 w_ovf_set;
   logic                 w_unf_set;
   logic [ADDR_BITS-1:0] w_waddr;
   logic [ADDR_BITS-1:0] w_raddr;

   assign w_full  = (r_count == DEPTH_C);
   assign w_empty = (r_count == '0);
   assign w_waddr = r_wptr[ADDR_BITS-1:0];
   assign w_raddr = r_rptr[ADDR_BITS-1:0];

   // A full FIFO still takes a write when a pop frees a slot in the same cycle.
   assign w_ra      = bus.re_i & ~w_empty & ~bus.flush_i;
   assign w_wa      = bus.we_i & (~w_full | (bus.re_i & ~w_empty)) & ~bus.flush_i;
   assign w_ovf_set = bus.we_i & ~w_wa & ~bus.flush_i;
   assign w_unf_set = bus.re_i & ~w_ra & ~bus.flush_i;

   // NOTE: storage has no reset; only pointers decide what is valid.
   always_ff @(posedge clk_i) begin
      if (w_wa) r_mem[w_waddr] <= bus.wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (bus.flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wa) r_wptr <= r_wptr + ONE_C;
         if (w_ra) r_rptr <= r_rptr + ONE_C;
         case ({w_wa, w_ra})
            2'b10:   r_count <= r_count + ONE_C;
            2'b01:   r_count <= r_count - ONE_C;
            default: r_count <= r_count;
         endcase
         // A new error in the clearing cycle wins over the clear.
         r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr_i);
         r_unf <= w_unf_set | (r_unf & ~bus.err_clr_i);
      end
   end

   assign bus.full_o         = w_full;
   assign bus.empty_o        = w_empty;
   assign bus.almost_full_o  = (r_count >= AF_C);
   assign bus.almost_empty_o = (r_count <= AE_C);
   assign bus.count_o        = r_count;
   assign bus.overflow_o     = r_ovf;
   assign bus.underflow_o    = r_unf;

   if (FWFT) begin : g_fwft
      assign bus.rdata_o  = w_empty ? '0 : r_mem[w_raddr];
      assign bus.rvalid_o = ~w_empty;
   end else begin : g_reg
      logic [WIDTH-1:0] r_rdata;
      logic             r_rvalid;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
         end else begin
            r_rvalid <= w_ra;
            if (w_ra) r_rdata <= r_mem[w_raddr];
         end
      end

      assign bus.rdata_o  = r_rdata;
      assign bus.rvalid_o = r_rvalid;
   end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one FWFT instance (depth 8) and one registered-read
// instance (depth 4), each checked every cycle against a queue-based model.
module tb_sync_fifo_flags;
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   sync_fifo_flags_if #(.WIDTH(8), .DEPTH(8)) ifa ();
   sync_fifo_flags_if #(.WIDTH(8), .DEPTH(4)) ifb ();

   sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1))
      u_fwft (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifa.slave));
   sync_fifo_flags #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b0))
      u_reg  (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifb.slave));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int depth_m [2] = '{8, 4};
   int af_m    [2] = '{6, 3};
   int ae_m    [2] = '{2, 1};
   bit fwft_m  [2] = '{1'b1, 1'b0};

   logic [7:0] mq   [2][$];
   logic [7:0] m_rd [2];
   bit         m_rv [2];
   bit         m_ovf[2];
   bit         m_unf[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         m_rd[k]  = '0;
         m_rv[k]  = 1'b0;
         m_ovf[k] = 1'b0;
         m_unf[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k, input logic fl, input logic ec,
                             input logic we, input logic re, input logic [7:0] wd);
      bit empty, full, ra, wa;
      empty = (mq[k].size() == 0);
      full  = (mq[k].size() == depth_m[k]);
      ra    = re && !empty;
      wa    = we && (!full || ra);
      if (fl) begin
         mq[k].delete();
         m_rv[k] = 1'b0;
         return;
      end
      m_rv[k] = ra;
      if (ra) m_rd[k] = mq[k].pop_front();
      if (wa) mq[k].push_back(wd);
      m_ovf[k] = (we && !wa) || (m_ovf[k] && !ec);
      m_unf[k] = (re && !ra) || (m_unf[k] && !ec);
   endtask

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) model_reset();
      else begin
         model_step(0, ifa.flush_i, ifa.err_clr_i, ifa.we_i, ifa.re_i, ifa.wdata_i);
         model_step(1, ifb.flush_i, ifb.err_clr_i, ifb.we_i, ifb.re_i, ifb.wdata_i);
      end
   end

   task automatic cmp(input string tag, input int k, input logic [7:0] rd, input logic rv,
                      input logic full, input logic empty, input logic af, input logic ae,
                      input logic [31:0] cnt, input logic ovf, input logic unf);
      int n;
      logic [7:0] exp_rd;
      n = mq[k].size();
      if (fwft_m[k]) exp_rd = (n != 0) ? mq[k][0] : 8'h00;
      else           exp_rd = m_rd[k];
      check({tag, ".count"},  cnt,   n);
      check({tag, ".full"},   32'(full),  32'(n == depth_m[k]));
      check({tag, ".empty"},  32'(empty), 32'(n == 0));
      check({tag, ".afull"},  32'(af),    32'(n >= af_m[k]));
      check({tag, ".aempty"}, 32'(ae),    32'(n <= ae_m[k]));
      check({tag, ".rvalid"}, 32'(rv),    fwft_m[k] ? 32'(n != 0) : 32'(m_rv[k]));
      check({tag, ".rdata"},  32'(rd),    32'(exp_rd));
      check({tag, ".ovf"},    32'(ovf),   32'(m_ovf[k]));
      check({tag, ".unf"},    32'(unf),   32'(m_unf[k]));
   endtask

   always @(negedge clk_i) begin
      if (rst_ni) begin
         cmp("A", 0, ifa.rdata_o, ifa.rvalid_o, ifa.full_o, ifa.empty_o, ifa.almost_full_o,
             ifa.almost_empty_o, 32'(ifa.count_o), ifa.overflow_o, ifa.underflow_o);
         cmp("B", 1, ifb.rdata_o, ifb.rvalid_o, ifb.full_o, ifb.empty_o, ifb.almost_full_o,
             ifb.almost_empty_o, 32'(ifb.count_o), ifb.overflow_o, ifb.underflow_o);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_a(input logic fl, input logic ec, input logic we,
                          input logic re, input logic [7:0] wd);
      ifa.flush_i = fl; ifa.err_clr_i = ec; ifa.we_i = we; ifa.re_i = re; ifa.wdata_i = wd;
   endtask

   task automatic drive_b(input logic fl, input logic ec, input logic we,
                          input logic re, input logic [7:0] wd);
      ifb.flush_i = fl; ifb.err_clr_i = ec; ifb.we_i = we; ifb.re_i = re; ifb.wdata_i = wd;
   endtask

   initial begin
      logic [7:0] drain [8];
      logic [7:0] wv;
      logic [7:0] rv;
      drain = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h99};
      drive_a(0, 0, 0, 0, 8'h00);
      drive_b(0, 0, 0, 0, 8'h00);

      // Reset state
      #12;
      check("rst.empty",  32'(ifa.empty_o), 1);
      check("rst.full",   32'(ifa.full_o), 0);
      check("rst.aempty", 32'(ifa.almost_empty_o), 1);
      check("rst.afull",  32'(ifa.almost_full_o), 0);
      check("rst.count",  32'(ifa.count_o), 0);
      check("rst.rvalid", 32'(ifb.rvalid_o), 0);
      check("rst.rdata",  32'(ifb.rdata_o), 0);
      #10 rst_ni = 1'b1;

      // Fill the FWFT FIFO: 0x11..0x18
      for (int i = 0; i < 8; i++) begin
         drive_a(0, 0, 1, 0, 8'h11 + 8'(i));
         tick();
         check("fill.count",  32'(ifa.count_o), i + 1);
         check("fill.aempty", 32'(ifa.almost_empty_o), 32'(i + 1 <= 2));
         check("fill.afull",  32'(ifa.almost_full_o), 32'(i + 1 >= 6));
         check("fill.head",   32'(ifa.rdata_o), 32'h11);
      end
      check("fill.full", 32'(ifa.full_o), 1);

      // Write while full is rejected; write+read while full is accepted
      drive_a(0, 0, 1, 0, 8'h77);
      tick();
      check("ovf.count", 32'(ifa.count_o), 8);
      check("ovf.flag",  32'(ifa.overflow_o), 1);
      drive_a(0, 0, 1, 1, 8'h99);
      tick();
      check("wr_rd_full.count", 32'(ifa.count_o), 8);
      check("wr_rd_full.head",  32'(ifa.rdata_o), 32'h12);
      for (int i = 0; i < 8; i++) begin
         drive_a(0, 0, 0, 0, 8'h00);
         check("drain.data", 32'(ifa.rdata_o), 32'(drain[i]));
         drive_a(0, 0, 0, 1, 8'h00);
         tick();
      end
      drive_a(0, 0, 0, 0, 8'h00);
      check("drain.empty", 32'(ifa.empty_o), 1);

      // Read+write on empty: read rejected, write accepted
      drive_a(0, 0, 1, 1, 8'hAA);
      tick();
      check("unf.flag",  32'(ifa.underflow_o), 1);
      check("unf.count", 32'(ifa.count_o), 1);
      check("unf.head",  32'(ifa.rdata_o), 32'hAA);
      drive_a(0, 0, 0, 1, 8'h00);
      tick();
      drive_a(0, 1, 0, 1, 8'h00);
      tick();
      check("clr_set.unf", 32'(ifa.underflow_o), 1);
      check("clr_set.ovf", 32'(ifa.overflow_o), 0);
      drive_a(0, 1, 0, 0, 8'h00);
      tick();
      check("clr.unf", 32'(ifa.underflow_o), 0);

      // Flush beats a same-cycle write/read and keeps sticky flags
      drive_a(0, 0, 0, 1, 8'h00);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive_a(0, 0, 1, 0, 8'h21 + 8'(i));
         tick();
      end
      drive_a(1, 0, 1, 1, 8'h55);
      tick();
      drive_a(0, 0, 0, 0, 8'h00);
      check("flush.count",  32'(ifa.count_o), 0);
      check("flush.empty",  32'(ifa.empty_o), 1);
      check("flush.rvalid", 32'(ifa.rvalid_o), 0);
      check("flush.unf",    32'(ifa.underflow_o), 1);
      check("flush.ovf",    32'(ifa.overflow_o), 0);
      tick();
      check("flush.nowrite", 32'(ifa.count_o), 0);

      // Asynchronous reset while half full
      for (int i = 0; i < 4; i++) begin
         drive_a(0, 0, 1, 0, 8'h31 + 8'(i));
         tick();
      end
      drive_a(0, 0, 0, 0, 8'h00);
      check("pre_rst.count", 32'(ifa.count_o), 4);
      #3 rst_ni = 1'b0;
      #1;
      check("arst.count", 32'(ifa.count_o), 0);
      check("arst.empty", 32'(ifa.empty_o), 1);
      check("arst.unf",   32'(ifa.underflow_o), 0);
      #7 rst_ni = 1'b1;
      tick();

      // Registered read: 1, 2, 3 each one cycle after its pop
      for (int i = 1; i <= 3; i++) begin
         drive_b(0, 0, 1, 0, 8'(i));
         tick();
      end
      drive_b(0, 0, 0, 0, 8'h00);
      check("reg.idle_rvalid", 32'(ifb.rvalid_o), 0);
      for (int i = 1; i <= 3; i++) begin
         drive_b(0, 0, 0, 1, 8'h00);
         tick();
         check("reg.rvalid", 32'(ifb.rvalid_o), 1);
         check("reg.rdata",  32'(ifb.rdata_o), i);
      end
      drive_b(0, 0, 0, 0, 8'h00);
      tick();
      check("reg.hold_rvalid", 32'(ifb.rvalid_o), 0);
      check("reg.hold_rdata",  32'(ifb.rdata_o), 3);

      // Pointer wrap on the depth-4 FIFO
      wv = 8'h40;
      rv = 8'h40;
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 3; i++) begin
            drive_b(0, 0, 1, 0, wv);
            wv++;
            tick();
         end
         for (int i = 0; i < 3; i++) begin
            drive_b(0, 0, 0, 1, 8'h00);
            tick();
            check("wrap.rdata", 32'(ifb.rdata_o), 32'(rv));
            rv++;
         end
      end
      drive_b(0, 0, 0, 0, 8'h00);
      check("wrap.empty", 32'(ifb.empty_o), 1);
      check("wrap.ovf",   32'(ifb.overflow_o), 0);
      check("wrap.unf",   32'(ifb.underflow_o), 0);

      // Flush in registered mode clears rvalid but keeps rdata
      drive_b(0, 0, 1, 0, 8'hC1); tick();
      drive_b(0, 0, 1, 0, 8'hC2); tick();
      drive_b(0, 0, 0, 1, 8'h00); tick();
      check("regfl.pop", 32'(ifb.rdata_o), 32'hC1);
      drive_b(1, 0, 0, 1, 8'h00); tick();
      drive_b(0, 0, 0, 0, 8'h00);
      check("regfl.rvalid", 32'(ifb.rvalid_o), 0);
      check("regfl.rdata",  32'(ifb.rdata_o), 32'hC1);
      check("regfl.empty",  32'(ifb.empty_o), 1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
